lcd12864_refresh: RTL

- Display-side consumer of the 64-byte character buffer RAM.
- After power-up, initialises an ST7920-based 128x64 LCD in 8-bit parallel, write-only mode.
- Then loops forever: reads the buffer (4 rows x 16 chars) and rewrites the LCD DDRAM.
- Keystroke logic writes the RAM independently; this block only reads it, through the RAM's synchronous read port.

---
 rtl/lcd12864_refresh.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd12864_refresh.sv
// lcd12864_refresh: refreshes an ST7920 128x64 LCD (8-bit parallel, write-only)
// from a 64-byte character buffer RAM read through its synchronous port.
// After power-up it runs the init command list once. It then rewrites the
// 4 rows x 16 chars of DDRAM in an endless loop.
// Optional build macro LCD_CTRL_FILTER_EN: fetched bytes outside 0x20..0x7E
// are shown as spaces.
module lcd12864_refresh #(
  parameter int POWERUP_CYC = 2000000,
  parameter int EN_CYC      = 50,
  parameter int CMD_CYC     = 4000,
  parameter int CLEAR_CYC   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  output logic       rs,
  output logic       rw,
  output logic       en,
  output logic [7:0] dat,
  output logic [5:0] address_out,
  input  logic [7:0] data_in,
  output logic       init_done,
  output logic       frame_done
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(POWERUP_CYC, EN_CYC), max2(CMD_CYC, CLEAR_CYC));
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] POWERUP_LAST = TW'(POWERUP_CYC - 1);
  localparam logic [TW-1:0] EN_LAST      = TW'(EN_CYC - 1);
  localparam logic [TW-1:0] CMD_LAST     = TW'(CMD_CYC - 1);
  localparam logic [TW-1:0] CLEAR_LAST   = TW'(CLEAR_CYC - 1);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_ROW_CMD,
    S_RD_ADDR,
    S_RD_WAIT,
    S_W_SETUP,
    S_W_EN,
    S_W_HOLD
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [2:0]      init_idx, init_idx_nx;
  logic [1:0]      row, row_nx;
  logic [3:0]      col, col_nx;
  logic            rs_nx, en_nx, init_done_nx, frame_done_nx;
  logic [7:0]      dat_nx;
  logic [5:0]      address_out_nx;
  logic [TW-1:0]   hold_last;

  // Init command list: function set (twice), display on, clear, entry mode
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h30;
      3'd1:    return 8'h30;
      3'd2:    return 8'h0C;
      3'd3:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // DDRAM base address of each text row (ST7920 interleaves rows 1/2)
  function automatic logic [7:0] row_cmd(input logic [1:0] r);
    case (r)
      2'd0:    return 8'h80;
      2'd1:    return 8'h90;
      2'd2:    return 8'h88;
      default: return 8'h98;
    endcase
  endfunction

  // Fetched character conditioning before it is put on the bus
  function automatic logic [7:0] char_filter(input logic [7:0] b);
`ifdef LCD_CTRL_FILTER_EN
    return ((b < 8'h20) || (b > 8'h7E)) ? 8'h20 : b;
`else
    return b;
`endif
  endfunction

  assign rw = 1'b0;

  // The clear command needs a much longer settle time than any other byte
  assign hold_last = (!rs && (dat == 8'h01)) ? CLEAR_LAST : CMD_LAST;

  // Sequencer and byte write engine: next-state and next-output values
  always_comb begin
    state_nx       = state;
    timer_nx       = timer;
    init_idx_nx    = init_idx;
    row_nx         = row;
    col_nx         = col;
    rs_nx          = rs;
    dat_nx         = dat;
    address_out_nx = address_out;
    init_done_nx   = init_done;
    frame_done_nx  = 1'b0;
    case (state)
      S_POWERUP: begin
        if (timer == POWERUP_LAST) begin
          timer_nx = '0;
          state_nx = S_INIT;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      S_INIT: begin
        dat_nx   = init_cmd(init_idx);
        rs_nx    = 1'b0;
        state_nx = S_W_SETUP;
      end
      S_ROW_CMD: begin
        dat_nx   = row_cmd(row);
        rs_nx    = 1'b0;
        state_nx = S_W_SETUP;
      end
      S_RD_ADDR: begin
        state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        dat_nx   = char_filter(data_in);
        rs_nx    = 1'b1;
        state_nx = S_W_SETUP;
      end
      S_W_SETUP: begin
        timer_nx = '0;
        state_nx = S_W_EN;
      end
      S_W_EN: begin
        if (timer == EN_LAST) begin
          timer_nx = '0;
          state_nx = S_W_HOLD;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      S_W_HOLD: begin
        if (timer == hold_last) begin
          timer_nx = '0;
          if (!init_done) begin
            if (init_idx == 3'd4) begin
              init_idx_nx  = '0;
              init_done_nx = 1'b1;
              row_nx       = '0;
              col_nx       = '0;
              state_nx     = S_ROW_CMD;
            end else begin
              init_idx_nx = init_idx + 3'd1;
              state_nx    = S_INIT;
            end
          end else if (!rs) begin
            // Row base command written: fetch the first char of the row.
            // The address is presented on entry to RD_ADDR so the RAM
            // result is ready two edges later when RD_WAIT ends.
            address_out_nx = {row, col};
            state_nx       = S_RD_ADDR;
          end else if (col != 4'd15) begin
            col_nx         = col + 4'd1;
            address_out_nx = {row, col + 4'd1};
            state_nx       = S_RD_ADDR;
          end else if (row != 2'd3) begin
            col_nx   = '0;
            row_nx   = row + 2'd1;
            state_nx = S_ROW_CMD;
          end else begin
            frame_done_nx = 1'b1;
            col_nx        = '0;
            row_nx        = '0;
            state_nx      = S_ROW_CMD;
          end
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = S_POWERUP;
    endcase
    en_nx = (state_nx == S_W_EN);
  end

  // State, counters and registered LCD/RAM outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_POWERUP;
      timer       <= '0;
      init_idx    <= '0;
      row         <= '0;
      col         <= '0;
      rs          <= 1'b0;
      en          <= 1'b0;
      dat         <= 8'h00;
      address_out <= '0;
      init_done   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      init_idx    <= init_idx_nx;
      row         <= row_nx;
      col         <= col_nx;
      rs          <= rs_nx;
      en          <= en_nx;
      dat         <= dat_nx;
      address_out <= address_out_nx;
      init_done   <= init_done_nx;
      frame_done  <= frame_done_nx;
    end
  end

endmodule
